cpu4_ifu: RTL
=============

# cpu4_ifu

Instruction fetch unit for the cpu4 core. Issues sequential word fetches to instruction memory over a valid/ready request channel with in-order responses, buffers returned words in a small prefetch FIFO, and presents them with their PC to the datapath's `instr` input through a valid/ready handshake. A redirect input (branch/jump target) flushes the buffer and discards in-flight responses from the old stream.

## Interface
- `DEPTH`, 2: prefetch FIFO entries; power of two, ≥2; also the cap on outstanding requests.
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `redirect` in 1: flush and restart fetch at `redirect_pc`.
- `redirect_pc` in 32: new fetch address; bits [1:0] ignored (forced 0).
- `imem_req_valid` out 1: fetch request valid.
- `imem_req_ready` in 1: memory accepts request.
- `imem_req_addr` out 32: word-aligned fetch address.
- `imem_rsp_valid` in 1: response valid; always accepted, in request order, ≥1 cycle after its request.
- `imem_rsp_data` in 32: fetched instruction word.
- `instr_valid` out 1: head of FIFO available.
- `instr_ready` in 1: consumer takes head this cycle.
- `instr` out 32: head instruction word.
- `instr_pc` out 32: address of `instr`.

## Operation
- Registers: `fetch_pc`, `head_pc`, `out_cnt` (outstanding), `drop_cnt`, FIFO count; all counters `$clog2(DEPTH)+1` bits.
- `req_fire = imem_req_valid & imem_req_ready`; `rsp_fire = imem_rsp_valid`; `deq = instr_valid & instr_ready`.
- `imem_req_valid = (out_cnt + fifo_count - deq) < DEPTH`; `imem_req_addr = fetch_pc`. Guarantees every live response has FIFO room.
- On `req_fire`: `fetch_pc += 4`, wrapping 32'hFFFF_FFFC → 0; `out_cnt` updates by `+req_fire - rsp_fire`.
- On `rsp_fire`: if `drop_cnt != 0`, discard word and decrement `drop_cnt`; else push into FIFO.
- On `deq`: pop FIFO, `head_pc += 4` (same wrap).
- Redirect (priority over all else in that cycle): `fetch_pc = head_pc = {redirect_pc[31:2],2'b00}`; FIFO cleared; any same-cycle push and pop ignored; `drop_cnt` ← next-cycle `out_cnt` (includes a request accepted this cycle, excludes a response arriving this cycle, which is itself dropped).
- Requests already asserted are not withdrawn mid-handshake except in the redirect cycle; `imem_req_addr` changes only after `req_fire` or redirect.
- `instr_valid = fifo_count != 0`; `instr`/`instr_pc` are don't-care when invalid.

## Timing
- Reset (asserted): `imem_req_valid=0`, `imem_req_addr=RESET_PC`, `instr_valid=0`, `instr=0`, `instr_pc=RESET_PC`, all counters 0. Reset mid-operation aborts everything; in-flight responses after reset release are the memory's responsibility to cancel.
- First cycle after reset release: `imem_req_valid=1`, addr `RESET_PC`.
- Latency: request accepted at cycle T, response at T+1 → `instr_valid` at T+2 (FIFO registered, no bypass).
- Throughput: 1 instruction/cycle sustained with a 1-cycle memory and `instr_ready` held high.
- FIFO full and `instr_ready` low: no new requests; in-flight responses still fit.
- Redirect at cycle T: first new request at T+1 with new address; `instr_valid=0` at T+1.

## Structure
- `RESET_PC` default and instruction width constants go in `defines.v`.
- One sub-module: `cpu4_ifu_fifo`, synchronous FIFO (DEPTH×32, push/pop/flush, count output); all control, counters and PC tracking in `cpu4_ifu`.

## Test plan
- Reset release, 1-cycle memory, `instr_ready=1` → requests 0x0,0x4,0x8…; `instr_valid` from cycle 2, `instr_pc` 0x0,0x4… one per cycle.
- `instr_ready=0` for 10 cycles → exactly DEPTH accepted requests, FIFO full, `imem_req_valid=0`; release → delivery resumes in order, no loss/duplicate.
- Redirect to 0x1003 with 2 responses in flight → both discarded, next request addr 0x1000, first delivered `instr_pc=0x1000`.
- Redirect same cycle as `rsp_fire` and `req_fire` → that response dropped, the accepted request's response dropped later, `drop_cnt` returns to 0.
- `redirect_pc=32'hFFFF_FFF8` → fetches 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000; `instr_pc` wraps identically.
- Random `imem_req_ready` stalls, 1–4 cycle response latency, random `instr_ready` → delivered stream matches scoreboard of sequential addresses.

Source files
------------

// File: rtl/cpu4_ifu_pkg.sv
// Shared constants and PC helpers for the cpu4 instruction fetch unit.
package cpu4_ifu_pkg;

  localparam int          XLEN         = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef logic [XLEN-1:0] word_t;

  // Sequential word step; 32'hFFFF_FFFC rolls over to 0 naturally.
  function automatic word_t pc_inc(input word_t pc);
    return pc + 32'd4;
  endfunction

  function automatic word_t pc_align(input word_t pc);
    return pc & ~32'd3;
  endfunction

endpackage

// File: rtl/cpu4_ifu_fifo.sv
// Prefetch buffer: DEPTH x 32 synchronous FIFO with flush and occupancy count.
module cpu4_ifu_fifo
  import cpu4_ifu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  input  word_t                      data_i,
  output word_t                      data_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  word_t          mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]  count_q;

  // Storage is reset so the head word reads as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/cpu4_ifu.sv
// cpu4 instruction fetch: sequential word requests, in-order responses into a
// prefetch FIFO, redirect flushes the buffer and drops stale in-flight words.
module cpu4_ifu
  import cpu4_ifu_pkg::*;
#(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  word_t          fetch_pc_q, fetch_pc_d;
  word_t          head_pc_q, head_pc_d;
  logic [CW-1:0]  out_cnt_q, out_cnt_d;
  logic [CW-1:0]  drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]  fifo_count;
  logic [CW:0]    occupancy;
  logic           req_fire, rsp_fire, deq, push, pop;

  assign deq       = instr_valid & instr_ready;
  assign req_fire  = imem_req_valid & imem_req_ready;
  assign rsp_fire  = imem_rsp_valid;

  // Reserve a FIFO slot for every outstanding request, so responses never stall.
  assign occupancy      = {1'b0, out_cnt_q} + {1'b0, fifo_count} - (CW+1)'(deq);
  assign imem_req_valid = reset & (occupancy < (CW+1)'(DEPTH));
  assign imem_req_addr  = fetch_pc_q;

  assign push = rsp_fire & (drop_cnt_q == '0) & ~redirect;
  assign pop  = deq & ~redirect;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    head_pc_d  = head_pc_q;
    drop_cnt_d = drop_cnt_q;
    out_cnt_d  = out_cnt_q + CW'(req_fire) - CW'(rsp_fire);
    if (redirect) begin
      fetch_pc_d = pc_align(redirect_pc);
      head_pc_d  = pc_align(redirect_pc);
      drop_cnt_d = out_cnt_d;
    end else begin
      if (req_fire) fetch_pc_d = pc_inc(fetch_pc_q);
      if (deq)      head_pc_d  = pc_inc(head_pc_q);
      if (rsp_fire && drop_cnt_q != '0) drop_cnt_d = drop_cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      head_pc_q  <= RESET_PC;
      out_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      head_pc_q  <= head_pc_d;
      out_cnt_q  <= out_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  cpu4_ifu_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect),
    .data_i  (imem_rsp_data),
    .data_o  (instr),
    .count_o (fifo_count)
  );

  assign instr_valid = (fifo_count != '0);
  assign instr_pc    = head_pc_q;

endmodule
